// File: rtl/gtech_deser5.sv
// Serial-in/parallel-out deserializer with valid/ready on both sides.
// Presents each completed word with a registered all-ones flag.
module gtech_deser5 #(
    parameter int WIDTH     = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SI,
    input  logic             SI_VALID,
    output logic             SI_READY,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] PO,
    output logic             PO_VALID,
    input  logic             PO_READY,
    output logic             ZALL
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word;
    logic             last;
    logic             take;
    logic             complete;
    logic             drain;

    assign last     = (cnt == LAST);
    assign PO_VALID = (state == FULL);
    // Only the word-completing bit can stall; partial bits always land.
    assign SI_READY = !(last && PO_VALID && !PO_READY);
    assign take     = SI_VALID && SI_READY && !FLUSH;
    assign complete = take && last;
    assign drain    = PO_VALID && PO_READY;
    assign word     = MSB_FIRST ? {sreg[WIDTH-2:0], SI}
                                : {SI, sreg[WIDTH-1:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (complete) state_nxt = FULL;
            FULL:  if (drain && !complete) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            sreg <= '0;
            PO   <= '0;
            ZALL <= 1'b0;
        end else if (FLUSH) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (take) begin
            if (last) begin
                PO   <= word;
                ZALL <= &word;
                cnt  <= '0;
                sreg <= '0;
            end else begin
                sreg <= word;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gtech_deser5.sv
// Scoreboard bench for gtech_deser5: MSB-first and LSB-first instances.
// Expected words are queued at stimulus time and checked by a monitor.
module tb_gtech_deser5;

    logic       clk = 1'b0;
    logic       rst;
    logic       si;
    logic       flush;
    logic       po_ready;
    logic       siv0, sir0, pv0, z0;
    logic       siv1, sir1, pv1, z1;
    logic [4:0] po0, po1;

    int checks = 0;
    int errors = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];

    always #5 clk = ~clk;

    gtech_deser5 #(.WIDTH(5), .MSB_FIRST(1'b1)) u0 (
        .CLK(clk), .RST(rst), .SI(si), .SI_VALID(siv0),
        .SI_READY(sir0), .FLUSH(flush), .PO(po0),
        .PO_VALID(pv0), .PO_READY(po_ready), .ZALL(z0)
    );

    gtech_deser5 #(.WIDTH(5), .MSB_FIRST(1'b0)) u1 (
        .CLK(clk), .RST(rst), .SI(si), .SI_VALID(siv1),
        .SI_READY(sir1), .FLUSH(flush), .PO(po1),
        .PO_VALID(pv1), .PO_READY(po_ready), .ZALL(z1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented word against the queue head,
    // popping only when the handshake completes at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (pv0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL u0_unexpected_word actual=%0h required=none", po0);
                end else begin
                    chk("u0_po", {27'b0, po0}, {27'b0, q0[0][5:1]});
                    chk("u0_zall", {31'b0, z0}, {31'b0, q0[0][0]});
                    if (po_ready) void'(q0.pop_front());
                end
            end
            if (pv1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL u1_unexpected_word actual=%0h required=none", po1);
                end else begin
                    chk("u1_po", {27'b0, po1}, {27'b0, q1[0][5:1]});
                    chk("u1_zall", {31'b0, z1}, {31'b0, q1[0][0]});
                    if (po_ready) void'(q1.pop_front());
                end
            end
        end
    end

    task automatic expect_w(input int u, input logic [4:0] w, input logic z);
        if (u == 0) q0.push_back({w, z});
        else q1.push_back({w, z});
    endtask

    task automatic send(input int u, input logic b);
        bit ok;
        ok = 1'b0;
        si = b;
        if (u == 0) siv0 = 1'b1;
        else siv1 = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((u == 0) ? sir0 : sir1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=si_ready");
        end
        @(posedge clk);
        #1;
        siv0 = 1'b0;
        siv1 = 1'b0;
    endtask

    // seq[4] is the first bit on the wire
    task automatic send5(input int u, input logic [4:0] seq);
        for (int i = 4; i >= 0; i--) send(u, seq[i]);
    endtask

    initial begin
        logic [4:0] t1;
        rst      = 1'b1;
        si       = 1'b0;
        flush    = 1'b0;
        po_ready = 1'b1;
        siv0     = 1'b0;
        siv1     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_po", {27'b0, po0}, 32'h0);
        chk("reset_pv", {31'b0, pv0}, 32'h0);
        chk("reset_zall", {31'b0, z0}, 32'h0);
        chk("reset_si_ready", {31'b0, sir0}, 32'h1);
        rst = 1'b0;

        // basic word, MSB first
        t1 = 5'b10110;
        expect_w(0, 5'b10110, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            send(0, t1[i]);
            chk("t1_si_ready", {31'b0, sir0}, 32'h1);
        end
        chk("t1_pv_latency", {31'b0, pv0}, 32'h1);

        // back-to-back words
        expect_w(0, 5'b11111, 1'b1);
        send5(0, 5'b11111);
        expect_w(0, 5'b01111, 1'b0);
        send5(0, 5'b01111);
        chk("t2_pv", {31'b0, pv0}, 32'h1);
        @(posedge clk);
        #1;
        chk("t2_drain", {31'b0, pv0}, 32'h0);
        chk("t2_po_hold", {27'b0, po0}, 32'h0f);

        // backpressure on the completing bit
        po_ready = 1'b0;
        expect_w(0, 5'b10101, 1'b0);
        send5(0, 5'b10101);
        chk("t3_pv", {31'b0, pv0}, 32'h1);
        chk("t3_ready_b1", {31'b0, sir0}, 32'h1);
        send(0, 1'b0);
        chk("t3_ready_b2", {31'b0, sir0}, 32'h1);
        send(0, 1'b1);
        chk("t3_ready_b3", {31'b0, sir0}, 32'h1);
        send(0, 1'b1);
        chk("t3_ready_b4", {31'b0, sir0}, 32'h1);
        send(0, 1'b0);
        expect_w(0, 5'b01101, 1'b0);
        si   = 1'b1;
        siv0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", {31'b0, sir0}, 32'h0);
            chk("t3_stall_po", {27'b0, po0}, 32'h15);
            @(posedge clk);
            #1;
        end
        po_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", {31'b0, sir0}, 32'h1);
        @(posedge clk);
        #1;
        siv0 = 1'b0;
        chk("t3_reload_pv", {31'b0, pv0}, 32'h1);
        chk("t3_reload_po", {27'b0, po0}, 32'h0d);
        @(posedge clk);
        #1;
        chk("t3_drain", {31'b0, pv0}, 32'h0);

        // flush drops partial word and the bit presented with it
        send(0, 1'b1);
        send(0, 1'b1);
        send(0, 1'b1);
        flush = 1'b1;
        si    = 1'b1;
        siv0  = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        siv0  = 1'b0;
        chk("t4_flush_pv", {31'b0, pv0}, 32'h0);
        chk("t4_flush_po", {27'b0, po0}, 32'h0d);
        expect_w(0, 5'b00001, 1'b0);
        send5(0, 5'b00001);
        @(posedge clk);
        #1;

        // asynchronous reset mid-cycle
        send(0, 1'b1);
        send(0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_po", {27'b0, po0}, 32'h0);
        chk("t5_rst_pv", {31'b0, pv0}, 32'h0);
        chk("t5_rst_zall", {31'b0, z0}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_w(0, 5'b11001, 1'b0);
        send5(0, 5'b11001);
        repeat (2) @(posedge clk);
        #1;

        // LSB-first instance
        expect_w(1, 5'b00001, 1'b0);
        send5(1, 5'b10000);
        expect_w(1, 5'b11111, 1'b1);
        send5(1, 5'b11111);
        expect_w(1, 5'b00011, 1'b0);
        send5(1, 5'b11000);
        repeat (3) @(posedge clk);
        #1;
        chk("u0_queue_empty", q0.size(), 32'h0);
        chk("u1_queue_empty", q1.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
